// File: rtl/if_stage.sv
// if_stage: instruction fetch with a single outstanding imem read, one-entry output slot
// and branch/jump redirect that flushes the slot and drops any in-flight response.
module if_stage #(
  parameter int                   WORD_SIZE = 32,
  parameter int                   ADDR_SIZE = 10,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [ADDR_SIZE-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic                 instr_valid,
  input  logic                 id_ready
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d, pc_pending_q, pc_pending_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d, pc_out_q, pc_out_d;
  logic                 discard_q, discard_d, valid_q, valid_d;
  logic                 hs, load, unused_ok;
  assign unused_ok   = ^redirect_pc[1:0];
  assign imem_req    = (state_q == REQ) && (!valid_q || id_ready) && !redirect;
  assign imem_addr   = pc_q[ADDR_SIZE+1:2];
  assign hs          = imem_req && imem_ready;
  assign load        = (state_q == WAIT) && imem_rvalid && !discard_q && !redirect;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_pending_d = pc_pending_q;
    discard_d    = discard_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (hs) begin
        pc_pending_d = pc_q;
        pc_d         = pc_q + WORD_SIZE'(4);
        state_d      = WAIT;
      end
      WAIT: if (imem_rvalid) begin
        discard_d = 1'b0;
        state_d   = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      instr_d  = imem_rdata;
      pc_out_d = pc_pending_q;
      valid_d  = 1'b1;
    end else if (valid_q && id_ready) valid_d = 1'b0;
    // redirect outranks everything; a response still owed in WAIT must be swallowed later
    if (redirect) begin
      pc_d      = {redirect_pc[WORD_SIZE-1:2], 2'b00};
      valid_d   = 1'b0;
      instr_d   = NOP_INSTR;
      discard_d = (state_q == WAIT && !imem_rvalid) ? 1'b1 : discard_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pc_pending_q <= '0;
      discard_q    <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_pending_q <= pc_pending_d;
      discard_q    <= discard_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed + random checks of if_stage against a latency-configurable memory
// and a reference model of the fetched/delivered PC streams.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst, redirect, imem_req, imem_ready, imem_rvalid, instr_valid, id_ready;
  logic [31:0] redirect_pc, imem_rdata, instr, pc_out;
  logic [9:0] imem_addr, raddr, s_addr;
  logic s_rst, s_hs;
  int total = 0, bad = 0, ndel = 0, lat = 1, cnt = 0;
  bit rand_rdy = 0, rand_lat = 0, pend = 0;
  logic [31:0] fetch_pc, exp_pc, p_instr, p_pc;
  logic p_rst = 1'b1, p_valid = 1'b0, p_idr = 1'b0, p_redir = 1'b0;

  if_stage dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .pc_out(pc_out), .instr_valid(instr_valid), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {12'hA5C, a, ~a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (instr_valid) break;
    end
    chk("wait_valid", instr_valid, 1);
  endtask

  task automatic sync_hs();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (imem_req && imem_ready) break;
    end
    chk("sync_hs", imem_req && imem_ready, 1);
  endtask

  task automatic redir_in_req(input logic [31:0] tgt);
    lat = 1;
    sync_hs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = tgt;
    @(negedge clk);
    chk("redir_req_gated", imem_req, 0);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_req_next", imem_req, 1);
    chk("redir_req_addr", imem_addr, {22'd0, tgt[11:2]});
  endtask

  // instruction memory: one request at a time, response after lat cycles
  initial begin
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      s_rst = rst; s_hs = imem_req && imem_ready; s_addr = imem_addr;
      @(posedge clk); #1;
      if (!s_rst) begin
        pend = 0; imem_rvalid = 1'b0;
      end else begin
        if (imem_rvalid) begin imem_rvalid = 1'b0; pend = 0; end
        if (s_hs) begin
          pend = 1; raddr = s_addr;
          cnt = rand_lat ? int'($urandom_range(1, 4)) : lat;
        end
        if (pend && !imem_rvalid) begin
          cnt--;
          if (cnt == 0) begin imem_rvalid = 1'b1; imem_rdata = mem_word(raddr); end
        end
      end
      if (!imem_rvalid) imem_rdata = $urandom;
      imem_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // reference model: issued addresses and delivered PCs each form a +4 stream restarted by redirect
  initial forever begin
    @(negedge clk);
    if (!p_rst) begin
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_instr", instr, NOP);
      chk("rst_pc_out", pc_out, 0);
      chk("rst_valid", instr_valid, 0);
    end else if (p_redir) begin
      chk("flush_valid", instr_valid, 0);
      chk("flush_instr", instr, NOP);
    end else if (p_valid && !p_idr) begin
      chk("hold_valid", instr_valid, 1);
      chk("hold_instr", instr, p_instr);
      chk("hold_pc", pc_out, p_pc);
    end
    if (!rst) begin
      fetch_pc = 32'h0; exp_pc = 32'h0;
    end else begin
      if (redirect) chk("req_gated", imem_req, 0);
      if (pend) chk("one_outstanding", imem_req, 0);
      if (instr_valid && !id_ready) chk("bp_no_req", imem_req, 0);
      if (imem_req && imem_ready) begin
        chk("fetch_addr", imem_addr, {22'd0, fetch_pc[11:2]});
        fetch_pc += 32'd4;
      end
      if (instr_valid && id_ready && !redirect) begin
        chk("deliver_pc", pc_out, exp_pc);
        chk("deliver_instr", instr, mem_word(exp_pc[11:2]));
        exp_pc += 32'd4;
        ndel++;
      end
      if (redirect) begin
        fetch_pc = {redirect_pc[31:2], 2'b00};
        exp_pc = fetch_pc;
      end
    end
    p_rst = rst; p_valid = instr_valid; p_idr = id_ready; p_redir = redirect;
    p_instr = instr; p_pc = pc_out;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req", imem_req, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_instr", instr, NOP);
    chk("reset_valid", instr_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_no_req", imem_req, 0);
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    for (int k = 0; k < 2; k++) begin
      wait_valid();
      chk("seq_pc", pc_out, 32'(4 * k));
      chk("seq_instr", instr, mem_word(10'(k)));
      @(negedge clk);
      chk("seq_gap", instr_valid, 0);
    end
    @(posedge clk); #1;
    id_ready = 1'b0;
    wait_valid();
    chk("bp_pc", pc_out, 32'h8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", instr_valid, 1);
      chk("bp_pc_hold", pc_out, 32'h8);
      chk("bp_instr_hold", instr, mem_word(10'd2));
      chk("bp_req", imem_req, 0);
    end
    lat = 4;
    @(posedge clk); #1;
    id_ready = 1'b1;
    @(negedge clk);
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 3);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h103;
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) break;
      chk("no_stale_valid", instr_valid, 0);
    end
    chk("wait_redir_req", imem_req, 1);
    chk("wait_redir_addr", imem_addr, 10'h40);
    wait_valid();
    chk("wait_redir_pc", pc_out, 32'h100);
    chk("wait_redir_instr", instr, mem_word(10'h40));
    lat = 2;
    sync_hs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h208;
    @(negedge clk);
    chk("coinc_req", imem_req, 0);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("coinc_valid", instr_valid, 0);
    chk("coinc_req_next", imem_req, 1);
    chk("coinc_addr", imem_addr, 10'h82);
    wait_valid();
    chk("coinc_pc", pc_out, 32'h208);
    redir_in_req(32'h300);
    wait_valid();
    chk("req_redir_pc", pc_out, 32'h300);
    redir_in_req(32'hFFFF_FFFC);
    wait_valid();
    chk("wrap_pc_top", pc_out, 32'hFFFF_FFFC);
    chk("wrap_instr_top", instr, mem_word(10'h3FF));
    wait_valid();
    chk("wrap_pc_zero", pc_out, 32'h0);
    chk("wrap_instr_zero", instr, mem_word(10'h0));
    lat = 3;
    sync_hs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midwait_req", imem_req, 0);
    chk("midwait_addr", imem_addr, 0);
    chk("midwait_instr", instr, NOP);
    chk("midwait_pc_out", pc_out, 0);
    chk("midwait_valid", instr_valid, 0);
    @(negedge clk);
    chk("midwait_restart", imem_req, 1);
    chk("midwait_restart_addr", imem_addr, 0);
    rand_rdy = 1; rand_lat = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      id_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom_range(0, 1) ? $urandom : {22'h3F_FFFF, 10'($urandom)};
      rst = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b1; redirect = 1'b0; id_ready = 1'b1;
    rand_rdy = 0; rand_lat = 0; lat = 1;
    repeat (10) @(negedge clk);
    chk("progress", ndel > 100, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
